// File: rtl/fmac2fib_rxctrl_gen.sv
// rtl/fmac2fib_rxctrl_gen.sv - FMAC RX FIFOs to bridge rf/rcf FIFOs receive controller
module fmac2fib_rxctrl_gen #(
    parameter int DATA_WIDTH    = 256,
    parameter int BCNT_WIDTH    = 64,
    parameter int BCNT_MSB      = 63,
    parameter int BCNT_LSB      = 48,
    parameter int DATA_PTR      = 10,
    parameter int MAX_PKT_BYTES = 2048,
    parameter int WR_THRESH     = 960,
    parameter int STAT_W        = 32
) (
    input  logic                  clk_fib,
    input  logic                  reset_,
    input  logic                  wrempty_rf,
    input  logic                  wrempty_rcf,
    input  logic [DATA_PTR:0]     wrusedw_rf,
    input  logic                  fib_rx_mac_data_empty,
    input  logic [DATA_WIDTH-1:0] fib_rx_mac_pkt_data,
    input  logic                  fib_rx_mac_ipcs_empty,
    input  logic [BCNT_WIDTH-1:0] fib_rx_mac_ipcs_data,
    output logic                  fib_rx_mac_rd,
    output logic                  fib_rx_mac_ipcs_rd,
    output logic                  wren_rf,
    output logic [DATA_WIDTH-1:0] datain_rf,
    output logic                  wren_rcf,
    output logic [BCNT_WIDTH-1:0] datain_rcf,
    output logic [STAT_W-1:0]     pkt_cnt,
    output logic [STAT_W-1:0]     drop_cnt,
    output logic                  busy,
    output logic                  test
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BW    = BCNT_MSB - BCNT_LSB + 1;

    typedef enum logic [2:0] {IDLE, BWAIT, BCNT, XFER, DRAIN_LAST} state_t;

    state_t                state;
    logic [BCNT_WIDTH-1:0] ipcs_q;
    logic [BW:0]           rd_left;
    logic                  rd_q;
    logic                  drop_q;
    logic [BW-1:0]         bcnt;
    logic [BW:0]           bcnt_round;
    logic [BW:0]           beats;
    logic                  drop_now;
    logic                  launch;
    logic                  unused_inputs;

    // Bridge FIFO empties are not part of the control decision.
    assign unused_inputs = &{1'b0, wrempty_rf, wrempty_rcf};

    assign bcnt       = fib_rx_mac_ipcs_data[BCNT_MSB:BCNT_LSB];
    assign bcnt_round = {1'b0, bcnt} + (BW+1)'(BYTES - 1);
    assign beats      = bcnt_round / (BW+1)'(BYTES);
    assign drop_now   = (bcnt == '0) || ({1'b0, bcnt} > (BW+1)'(MAX_PKT_BYTES));
    assign launch     = (wrusedw_rf < (DATA_PTR+1)'(WR_THRESH)) &&
                        !fib_rx_mac_ipcs_empty && !fib_rx_mac_data_empty;

    // Pop uses this cycle's empty so a FIFO that runs dry mid-packet is never overread.
    assign fib_rx_mac_rd = (state == XFER) && (rd_left != '0) && !fib_rx_mac_data_empty;

    always_ff @(posedge clk_fib) begin
        if (!reset_) begin
            state              <= IDLE;
            ipcs_q             <= '0;
            rd_left            <= '0;
            rd_q               <= 1'b0;
            drop_q             <= 1'b0;
            fib_rx_mac_ipcs_rd <= 1'b0;
            wren_rf            <= 1'b0;
            datain_rf          <= '0;
            wren_rcf           <= 1'b0;
            datain_rcf         <= '0;
            pkt_cnt            <= '0;
            drop_cnt           <= '0;
            busy               <= 1'b0;
            test               <= 1'b0;
        end else begin
            rd_q               <= fib_rx_mac_rd;
            wren_rf            <= rd_q && !drop_q;
            wren_rcf           <= 1'b0;
            test               <= 1'b0;
            fib_rx_mac_ipcs_rd <= 1'b0;
            if (rd_q) begin
                datain_rf <= fib_rx_mac_pkt_data;
            end
            if (fib_rx_mac_rd) begin
                rd_left <= rd_left - (BW+1)'(1);
            end
            case (state)
                IDLE: begin
                    if (launch) begin
                        fib_rx_mac_ipcs_rd <= 1'b1;
                        state              <= BWAIT;
                        busy               <= 1'b1;
                    end
                end
                BWAIT: begin
                    state <= BCNT;
                end
                BCNT: begin
                    ipcs_q <= fib_rx_mac_ipcs_data;
                    drop_q <= drop_now;
                    if (bcnt == '0) begin
                        test     <= 1'b1;
                        drop_cnt <= drop_cnt + STAT_W'(1);
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        rd_left <= beats;
                        state   <= XFER;
                    end
                end
                XFER: begin
                    if (fib_rx_mac_rd && (rd_left == (BW+1)'(1))) begin
                        state <= DRAIN_LAST;
                    end
                end
                DRAIN_LAST: begin
                    // Final beat lands this cycle; the count word goes out alongside it.
                    if (drop_q) begin
                        drop_cnt <= drop_cnt + STAT_W'(1);
                        test     <= 1'b1;
                    end else begin
                        wren_rcf   <= 1'b1;
                        datain_rcf <= ipcs_q;
                        pkt_cnt    <= pkt_cnt + STAT_W'(1);
                    end
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fmac2fib_rxctrl_gen.sv
// tb/tb_fmac2fib_rxctrl_gen.sv - self-checking bench for fmac2fib_rxctrl_gen
module tb_fmac2fib_rxctrl_gen;
    localparam int DW  = 256;
    localparam int BY  = 32;
    localparam int BCW = 64;
    localparam int DP  = 10;
    localparam int SW  = 32;

    logic          clk_fib = 1'b0;
    logic          reset_ = 1'b0;
    logic          wrempty_rf = 1'b1;
    logic          wrempty_rcf = 1'b1;
    logic [DP:0]   wrusedw_rf = '0;
    logic          fib_rx_mac_data_empty = 1'b1;
    logic [DW-1:0] fib_rx_mac_pkt_data = '0;
    logic          fib_rx_mac_ipcs_empty = 1'b1;
    logic [BCW-1:0] fib_rx_mac_ipcs_data = '0;
    logic          fib_rx_mac_rd;
    logic          fib_rx_mac_ipcs_rd;
    logic          wren_rf;
    logic [DW-1:0] datain_rf;
    logic          wren_rcf;
    logic [BCW-1:0] datain_rcf;
    logic [SW-1:0] pkt_cnt;
    logic [SW-1:0] drop_cnt;
    logic          busy;
    logic          test;

    fmac2fib_rxctrl_gen dut (
        .clk_fib(clk_fib), .reset_(reset_), .wrempty_rf(wrempty_rf), .wrempty_rcf(wrempty_rcf),
        .wrusedw_rf(wrusedw_rf), .fib_rx_mac_data_empty(fib_rx_mac_data_empty),
        .fib_rx_mac_pkt_data(fib_rx_mac_pkt_data), .fib_rx_mac_ipcs_empty(fib_rx_mac_ipcs_empty),
        .fib_rx_mac_ipcs_data(fib_rx_mac_ipcs_data), .fib_rx_mac_rd(fib_rx_mac_rd),
        .fib_rx_mac_ipcs_rd(fib_rx_mac_ipcs_rd), .wren_rf(wren_rf), .datain_rf(datain_rf),
        .wren_rcf(wren_rcf), .datain_rcf(datain_rcf), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt),
        .busy(busy), .test(test)
    );

    always #5 clk_fib = ~clk_fib;

    int n_checks = 0;
    int n_fail = 0;
    int n_dpop = 0, n_ipop = 0, n_wrf = 0, n_wrcf = 0, n_test = 0;
    int pkt_id = 0, fwd_total = 0, drop_total = 0, last_id = -1;
    bit force_de = 1'b0;

    logic [DW-1:0]  dq[$];
    logic [BCW-1:0] iq[$];
    logic [DW-1:0]  exp_rf_d[$];
    int             exp_rf_id[$];
    logic [BCW-1:0] exp_rcf_w[$];
    int             exp_rcf_ord[$];
    int             exp_rcf_id[$];
    int             exp_drop_ord[$];

    task automatic chk(input bit ok, input string name, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // FMAC FIFO models: read data appears the cycle after a sampled pop.
    always @(posedge clk_fib) begin
        if (!reset_) begin
            dq.delete();
            iq.delete();
            fib_rx_mac_pkt_data  <= '0;
            fib_rx_mac_ipcs_data <= '0;
        end else begin
            if (fib_rx_mac_rd) begin
                chk(dq.size() != 0, "data_underflow", 0, 1);
                if (dq.size() != 0) begin
                    fib_rx_mac_pkt_data <= dq.pop_front();
                    n_dpop++;
                end
            end
            if (fib_rx_mac_ipcs_rd) begin
                chk(iq.size() != 0, "ipcs_underflow", 0, 1);
                if (iq.size() != 0) begin
                    fib_rx_mac_ipcs_data <= iq.pop_front();
                    n_ipop++;
                end
            end
        end
    end

    always @(negedge clk_fib) begin
        #1;
        fib_rx_mac_data_empty = (dq.size() == 0) || force_de;
        fib_rx_mac_ipcs_empty = (iq.size() == 0);
    end

    // Scoreboard compare against the packet-level model.
    always @(negedge clk_fib) begin
        logic [DW-1:0]  d;
        logic [BCW-1:0] w;
        int ord, id;
        #3;
        if (reset_) begin
            if (fib_rx_mac_rd) begin
                chk(!fib_rx_mac_data_empty, "rd_while_empty", fib_rx_mac_data_empty, 0);
                chk(!fib_rx_mac_ipcs_rd, "rd_with_ipcs_rd", fib_rx_mac_ipcs_rd, 0);
            end
            if (wren_rf) begin
                n_wrf++;
                if (exp_rf_d.size() == 0) begin
                    chk(1'b0, "unexpected_wren_rf", datain_rf, 0);
                end else begin
                    d = exp_rf_d.pop_front();
                    id = exp_rf_id.pop_front();
                    chk(datain_rf === d, "datain_rf", datain_rf, d);
                    last_id = id;
                end
            end
            if (wren_rcf) begin
                n_wrcf++;
                if (exp_rcf_w.size() == 0) begin
                    chk(1'b0, "unexpected_wren_rcf", datain_rcf, 0);
                end else begin
                    w = exp_rcf_w.pop_front();
                    ord = exp_rcf_ord.pop_front();
                    id = exp_rcf_id.pop_front();
                    chk(datain_rcf === w, "datain_rcf", datain_rcf, w);
                    chk(pkt_cnt == SW'(ord), "pkt_cnt_at_rcf", pkt_cnt, ord);
                    chk(wren_rf && last_id == id, "rcf_with_last_beat", {wren_rf, 32'(last_id)}, {1'b1, 32'(id)});
                    chk(exp_rf_id.size() == 0 || exp_rf_id[0] != id, "rcf_beats_left", 1, 0);
                end
            end
            if (test) begin
                n_test++;
                if (exp_drop_ord.size() == 0) begin
                    chk(1'b0, "unexpected_test", drop_cnt, 0);
                end else begin
                    ord = exp_drop_ord.pop_front();
                    chk(drop_cnt == SW'(ord), "drop_cnt_at_test", drop_cnt, ord);
                end
            end
        end
    end

    task automatic push_pkt(input int bcnt);
        int nb;
        bit drop;
        logic [BCW-1:0] w;
        logic [DW-1:0]  d;
        nb = (bcnt + BY - 1) / BY;
        drop = (bcnt == 0) || (bcnt > 2048);
        pkt_id++;
        w = {bcnt[15:0], 32'($urandom()), 16'($urandom())};
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom();
            dq.push_back(d);
            if (!drop) begin
                exp_rf_d.push_back(d);
                exp_rf_id.push_back(pkt_id);
            end
        end
        if (!drop) begin
            fwd_total++;
            exp_rcf_w.push_back(w);
            exp_rcf_ord.push_back(fwd_total);
            exp_rcf_id.push_back(pkt_id);
        end else begin
            drop_total++;
            exp_drop_ord.push_back(drop_total);
        end
        iq.push_back(w);
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int c = 0;
        bit done = 1'b0;
        while (!done && c < budget) begin
            @(negedge clk_fib);
            c++;
            if (rnd) begin
                force_de = ($urandom_range(0, 4) == 0);
                wrusedw_rf = 11'($urandom_range(0, 1023));
            end
            #4;
            done = (iq.size() == 0) && (dq.size() == 0) && !busy && (exp_rf_d.size() == 0) &&
                   (exp_rcf_w.size() == 0) && (exp_drop_ord.size() == 0);
        end
        chk(done, "drain_timeout", c, budget);
        force_de = 1'b0;
        wrusedw_rf = '0;
    endtask

    initial begin
        int d0, w0, r0, i0, t0, bc, g0, cnt;
        bit hit;
        repeat (3) @(negedge clk_fib);
        #4;
        chk({fib_rx_mac_rd, fib_rx_mac_ipcs_rd, wren_rf, wren_rcf, busy, test} == 6'b0, "reset_flags",
            {fib_rx_mac_rd, fib_rx_mac_ipcs_rd, wren_rf, wren_rcf, busy, test}, 0);
        chk(pkt_cnt == 0 && drop_cnt == 0, "reset_counters", {pkt_cnt, drop_cnt}, 0);
        chk(datain_rf == 0 && datain_rcf == 0, "reset_data", datain_rcf, 0);
        @(negedge clk_fib);
        reset_ = 1'b1;

        // 64 bytes: two beats, one count word
        d0 = n_dpop; w0 = n_wrf; r0 = n_wrcf; i0 = n_ipop;
        push_pkt(64);
        wait_done(200, 0);
        chk(n_ipop - i0 == 1, "t1_ipcs_pops", n_ipop - i0, 1);
        chk(n_dpop - d0 == 2, "t1_data_pops", n_dpop - d0, 2);
        chk(n_wrf - w0 == 2, "t1_wren_rf", n_wrf - w0, 2);
        chk(n_wrcf - r0 == 1, "t1_wren_rcf", n_wrcf - r0, 1);
        chk(pkt_cnt == 1, "t1_pkt_cnt", pkt_cnt, 1);

        // 1 byte then 33 bytes back to back
        d0 = n_dpop; r0 = n_wrcf;
        push_pkt(1);
        push_pkt(33);
        wait_done(200, 0);
        chk(n_dpop - d0 == 3, "t2_data_pops", n_dpop - d0, 3);
        chk(n_wrcf - r0 == 2, "t2_wren_rcf", n_wrcf - r0, 2);
        chk(pkt_cnt == 3, "t2_pkt_cnt", pkt_cnt, 3);

        // 96 bytes with the data FIFO held empty for 3 cycles after the first pop
        d0 = n_dpop; w0 = n_wrf;
        push_pkt(96);
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk_fib);
            if (n_dpop != d0) begin
                hit = 1'b1;
                force_de = 1'b1;
            end
        end
        chk(hit, "t3_first_pop_timeout", 0, 1);
        g0 = n_dpop;
        repeat (3) @(negedge clk_fib);
        chk(n_dpop == g0, "t3_no_pop_in_gap", n_dpop - g0, 0);
        force_de = 1'b0;
        wait_done(200, 0);
        chk(n_dpop - d0 == 3, "t3_data_pops", n_dpop - d0, 3);
        chk(n_wrf - w0 == 3, "t3_wren_rf", n_wrf - w0, 3);

        // Oversize packet is drained and discarded, then a normal one forwards
        d0 = n_dpop; w0 = n_wrf; r0 = n_wrcf; t0 = n_test;
        push_pkt(4000);
        wait_done(600, 0);
        chk(n_dpop - d0 == 125, "t4_data_pops", n_dpop - d0, 125);
        chk(n_wrf == w0 && n_wrcf == r0, "t4_no_writes", n_wrf - w0, 0);
        chk(drop_cnt == 1, "t4_drop_cnt", drop_cnt, 1);
        chk(n_test - t0 == 1, "t4_test_pulses", n_test - t0, 1);
        r0 = n_wrcf;
        push_pkt(64);
        wait_done(200, 0);
        chk(n_wrcf - r0 == 1 && pkt_cnt == 5, "t4_next_pkt", pkt_cnt, 5);

        // Zero-length packet consumes no data
        d0 = n_dpop;
        push_pkt(0);
        push_pkt(32);
        wait_done(200, 0);
        chk(n_dpop - d0 == 1, "t5_data_pops", n_dpop - d0, 1);
        chk(drop_cnt == 2 && pkt_cnt == 6, "t5_counts", {pkt_cnt, drop_cnt}, {32'd6, 32'd2});

        // Admission threshold
        i0 = n_ipop;
        wrusedw_rf = 11'd960;
        push_pkt(64);
        repeat (20) @(negedge clk_fib);
        #4;
        chk(n_ipop == i0 && !busy, "t6_thresh_hold", n_ipop - i0, 0);
        @(negedge clk_fib);
        wrusedw_rf = 11'd959;
        wait_done(200, 0);
        chk(n_ipop - i0 == 1 && pkt_cnt == 7, "t6_thresh_launch", pkt_cnt, 7);

        // Randomized packets, stalls and occupancy
        t0 = n_test;
        cnt = drop_total;
        for (int p = 0; p < 40; p++) begin
            case ($urandom_range(0, 19))
                0: bc = 0;
                1: bc = $urandom_range(2049, 3000);
                2, 3, 4, 5, 6, 7, 8, 9: bc = $urandom_range(1, 128);
                default: bc = $urandom_range(1, 2048);
            endcase
            push_pkt(bc);
        end
        push_pkt(64);
        wait_done(30000, 1);
        chk(pkt_cnt == SW'(fwd_total), "rand_pkt_cnt", pkt_cnt, fwd_total);
        chk(drop_cnt == SW'(drop_total), "rand_drop_cnt", drop_cnt, drop_total);
        chk(n_test - t0 == drop_total - cnt, "rand_test_pulses", n_test - t0, drop_total - cnt);

        // Reset at the second beat of a 10-beat packet
        @(negedge clk_fib);
        d0 = n_dpop; r0 = n_wrcf;
        push_pkt(320);
        hit = 1'b0;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk_fib);
            if (n_dpop != d0) hit = 1'b1;
        end
        chk(hit, "t7_first_pop_timeout", 0, 1);
        reset_ = 1'b0;
        exp_rf_d.delete(); exp_rf_id.delete();
        exp_rcf_w.delete(); exp_rcf_ord.delete(); exp_rcf_id.delete(); exp_drop_ord.delete();
        @(negedge clk_fib);
        #4;
        chk({fib_rx_mac_rd, fib_rx_mac_ipcs_rd, wren_rf, wren_rcf, busy, test} == 6'b0, "t7_reset_flags",
            {fib_rx_mac_rd, fib_rx_mac_ipcs_rd, wren_rf, wren_rcf, busy, test}, 0);
        chk(pkt_cnt == 0 && drop_cnt == 0, "t7_reset_counters", {pkt_cnt, drop_cnt}, 0);
        @(negedge clk_fib);
        reset_ = 1'b1;
        repeat (10) @(negedge clk_fib);
        #4;
        chk(n_wrcf == r0 && pkt_cnt == 0 && !busy, "t7_after_reset", n_wrcf - r0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
